// File: rtl/frame_select_pkg.sv
// Shared types and helpers for the frame strobe sequencer.
package frame_select_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } fss_state_e;

    localparam int unsigned MinCntWidth = 1;

    function automatic int unsigned cnt_width(
        input int unsigned setup_cycles,
        input int unsigned strobe_cycles,
        input int unsigned hold_cycles
    );
        int unsigned m;
        m = setup_cycles;
        if (strobe_cycles > m) m = strobe_cycles;
        if (hold_cycles > m) m = hold_cycles;
        if ($clog2(m + 1) < MinCntWidth) return MinCntWidth;
        return $clog2(m + 1);
    endfunction

    function automatic logic range_err(
        input int unsigned col,
        input int unsigned frame,
        input logic        broadcast,
        input int unsigned num_cols,
        input int unsigned num_frames
    );
        return (frame >= num_frames) || (!broadcast && (col >= num_cols));
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame decode into a flat one-hot strobe vector.
module frame_strobe_decoder #(
    parameter int unsigned NumCols          = 17,
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned FrameIndexWidth  = 5
) (
    input  logic [FrameSelectWidth-1:0]         col_i,
    input  logic [FrameIndexWidth-1:0]          frame_i,
    input  logic                                broadcast_i,
    output logic [NumCols*MaxFramesPerCol-1:0] strobe_o
);

    always_comb begin
        strobe_o = '0;
        for (int c = 0; c < int'(NumCols); c++) begin
            for (int f = 0; f < int'(MaxFramesPerCol); f++) begin
                strobe_o[c*MaxFramesPerCol+f] =
                    (broadcast_i || (col_i == c[FrameSelectWidth-1:0])) &&
                    (frame_i == f[FrameIndexWidth-1:0]);
            end
        end
    end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Sequenced frame-write strobe generator with setup/strobe/hold phases.
module frame_strobe_sequencer
    import frame_select_pkg::*;
#(
    parameter int unsigned NumCols          = 17,
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned FrameIndexWidth  = 5,
    parameter int unsigned SetupCycles      = 1,
    parameter int unsigned StrobeCycles     = 1,
    parameter int unsigned HoldCycles       = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                CmdValid,
    output logic                                CmdReady,
    input  logic [FrameSelectWidth-1:0]         CmdCol,
    input  logic [FrameIndexWidth-1:0]          CmdFrame,
    input  logic                                CmdBroadcast,
    output logic [NumCols*MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                                Busy,
    output logic                                Done,
    output logic                                CmdErr
);

    localparam int unsigned StrobeW = NumCols * MaxFramesPerCol;
    localparam int unsigned CntW =
        cnt_width(SetupCycles, StrobeCycles, HoldCycles);

    localparam logic [CntW-1:0] SetupLoad =
        CntW'((SetupCycles > 0) ? SetupCycles - 1 : 0);
    localparam logic [CntW-1:0] StrobeLoad =
        CntW'((StrobeCycles > 0) ? StrobeCycles - 1 : 0);
    localparam logic [CntW-1:0] HoldLoad =
        CntW'((HoldCycles > 0) ? HoldCycles - 1 : 0);

    fss_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [StrobeW-1:0]   pat_q, pat_d;
    logic [StrobeW-1:0]   strobe_q, strobe_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [StrobeW-1:0]   dec;
    logic                 accept;
    logic                 cmd_bad;

    frame_strobe_decoder #(
        .NumCols          (NumCols),
        .MaxFramesPerCol  (MaxFramesPerCol),
        .FrameSelectWidth (FrameSelectWidth),
        .FrameIndexWidth  (FrameIndexWidth)
    ) u_dec (
        .col_i       (CmdCol),
        .frame_i     (CmdFrame),
        .broadcast_i (CmdBroadcast),
        .strobe_o    (dec)
    );

    assign accept  = CmdValid && CmdReady;
    assign cmd_bad = range_err(32'(CmdCol), 32'(CmdFrame), CmdBroadcast,
                               NumCols, MaxFramesPerCol);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !cmd_bad) begin
                    if (SetupCycles > 0) begin
                        state_d = SETUP;
                        cnt_d   = SetupLoad;
                    end else begin
                        state_d = STROBE;
                        cnt_d   = StrobeLoad;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (HoldCycles > 0) begin
                        state_d = HOLD;
                        cnt_d   = HoldLoad;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - CntW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero setup the accept edge enters STROBE, so the fresh decode is used.
    always_comb begin
        CmdReady = (state_q == IDLE) && !RST;
        Busy     = (state_q != IDLE);
        pat_d    = (accept && !cmd_bad) ? dec : pat_q;
        strobe_d = '0;
        if (state_d == STROBE) strobe_d = pat_d;
        done_d   = (state_q != IDLE) && (state_d == IDLE);
        err_d    = accept && cmd_bad;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_q    <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign FrameStrobe_O = strobe_q;
    assign Done          = done_q;
    assign CmdErr        = err_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer across three phase configurations.
module tb_frame_strobe_sequencer;

    localparam int W = 340;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         va, rdy_a, busy_a, done_a, err_a, bc_a;
    logic [4:0]   col_a, fr_a;
    logic [W-1:0] fs_a;
    logic         vb, rdy_b, busy_b, done_b, err_b, bc_b;
    logic [4:0]   col_b, fr_b;
    logic [W-1:0] fs_b;
    logic         vc, rdy_c, busy_c, done_c, err_c, bc_c;
    logic [4:0]   col_c, fr_c;
    logic [W-1:0] fs_c;

    int n_checks = 0;
    int n_pass   = 0;

    frame_strobe_sequencer dut_a (
        .CLK(clk), .RST(rst), .CmdValid(va), .CmdReady(rdy_a),
        .CmdCol(col_a), .CmdFrame(fr_a), .CmdBroadcast(bc_a),
        .FrameStrobe_O(fs_a), .Busy(busy_a), .Done(done_a), .CmdErr(err_a)
    );

    frame_strobe_sequencer #(
        .SetupCycles(0), .StrobeCycles(3), .HoldCycles(0)
    ) dut_b (
        .CLK(clk), .RST(rst), .CmdValid(vb), .CmdReady(rdy_b),
        .CmdCol(col_b), .CmdFrame(fr_b), .CmdBroadcast(bc_b),
        .FrameStrobe_O(fs_b), .Busy(busy_b), .Done(done_b), .CmdErr(err_b)
    );

    frame_strobe_sequencer #(
        .SetupCycles(1), .StrobeCycles(4), .HoldCycles(1)
    ) dut_c (
        .CLK(clk), .RST(rst), .CmdValid(vc), .CmdReady(rdy_c),
        .CmdCol(col_c), .CmdFrame(fr_c), .CmdBroadcast(bc_c),
        .FrameStrobe_O(fs_c), .Busy(busy_c), .Done(done_c), .CmdErr(err_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] onehot(input int idx);
        logic [W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rdy_a !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy_a);
        else n_pass++;
        n_checks++;
        if (fs_a !== '0) $display("FAIL reset_strobe: got %h want 0", fs_a);
        else n_pass++;
        n_checks++;
        if ({busy_a, done_a, err_a} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, err_a});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy_a !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", rdy_a);
        else n_pass++;
    endtask

    task automatic test_single();
        col_a = 5'd3; fr_a = 5'd7; bc_a = 1'b0; va = 1'b1;
        tick();
        va = 1'b0;
        n_checks++;
        if ({rdy_a, busy_a, fs_a == '0} !== 3'b011)
            $display("FAIL single_t1: got rdy/busy/zero=%b want 011",
                     {rdy_a, busy_a, fs_a == '0});
        else n_pass++;
        tick();
        n_checks++;
        if (fs_a !== onehot(67)) $display("FAIL single_strobe: got %h want %h", fs_a, onehot(67));
        else n_pass++;
        n_checks++;
        if (rdy_a !== 1'b0) $display("FAIL single_t2_ready: got %b want 0", rdy_a);
        else n_pass++;
        tick();
        n_checks++;
        if ({rdy_a, done_a, fs_a == '0} !== 3'b001)
            $display("FAIL single_t3: got rdy/done/zero=%b want 001",
                     {rdy_a, done_a, fs_a == '0});
        else n_pass++;
        tick();
        n_checks++;
        if ({done_a, rdy_a, busy_a} !== 3'b110)
            $display("FAIL single_done: got done/rdy/busy=%b want 110",
                     {done_a, rdy_a, busy_a});
        else n_pass++;
        tick();
        n_checks++;
        if (done_a !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done_a);
        else n_pass++;
    endtask

    task automatic test_broadcast();
        logic [W-1:0] exp;
        int hi;
        int dn;
        int bad;
        exp = '0;
        for (int c = 0; c < 17; c++) exp[c*20+19] = 1'b1;
        hi = 0; dn = 0; bad = 0;
        col_a = 5'd31; fr_a = 5'd19; bc_a = 1'b1; va = 1'b1;
        tick();
        va = 1'b0; bc_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (fs_a != '0) begin
                hi++;
                if (fs_a !== exp) bad++;
            end
            if (done_a) dn++;
            tick();
        end
        n_checks++;
        if (hi !== 1) $display("FAIL bcast_cycles: got %0d want 1", hi);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL bcast_pattern: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (dn !== 1) $display("FAIL bcast_done: got %0d want 1", dn);
        else n_pass++;
    endtask

    task automatic test_errors();
        int seen;
        col_a = 5'd17; fr_a = 5'd0; bc_a = 1'b0; va = 1'b1;
        tick();
        va = 1'b0;
        n_checks++;
        if ({err_a, rdy_a, busy_a, done_a} !== 4'b1100)
            $display("FAIL err_col: got err/rdy/busy/done=%b want 1100",
                     {err_a, rdy_a, busy_a, done_a});
        else n_pass++;
        tick();
        n_checks++;
        if (err_a !== 1'b0) $display("FAIL err_col_pulse: got %b want 0", err_a);
        else n_pass++;
        col_a = 5'd0; fr_a = 5'd20; va = 1'b1;
        tick();
        va = 1'b0;
        n_checks++;
        if ({err_a, rdy_a, done_a} !== 3'b110)
            $display("FAIL err_frame: got err/rdy/done=%b want 110",
                     {err_a, rdy_a, done_a});
        else n_pass++;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (fs_a != '0 || done_a || err_a || !rdy_a) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL err_quiet: got %0d active cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hi1;
        int hi2;
        col_b = 5'd2; fr_b = 5'd5; bc_b = 1'b0; vb = 1'b1;
        tick();
        col_b = 5'd4; fr_b = 5'd1;
        hi1 = 0;
        for (int k = 0; k < 3; k++) begin
            if (fs_b === onehot(45) && !rdy_b) hi1++;
            tick();
        end
        n_checks++;
        if (hi1 !== 3) $display("FAIL b2b_first_strobe: got %0d want 3", hi1);
        else n_pass++;
        n_checks++;
        if ({done_b, rdy_b, fs_b == '0} !== 3'b111)
            $display("FAIL b2b_done: got done/rdy/zero=%b want 111",
                     {done_b, rdy_b, fs_b == '0});
        else n_pass++;
        tick();
        vb = 1'b0;
        hi2 = 0;
        for (int k = 0; k < 3; k++) begin
            if (fs_b === onehot(81) && !done_b) hi2++;
            tick();
        end
        n_checks++;
        if (hi2 !== 3) $display("FAIL b2b_second_strobe: got %0d want 3", hi2);
        else n_pass++;
        n_checks++;
        if ({done_b, rdy_b} !== 2'b11)
            $display("FAIL b2b_second_done: got done/rdy=%b want 11", {done_b, rdy_b});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dn;
        int hi;
        int bad;
        col_c = 5'd0; fr_c = 5'd0; bc_c = 1'b0; vc = 1'b1;
        tick();
        vc = 1'b0;
        tick();
        n_checks++;
        if (fs_c !== onehot(0)) $display("FAIL rstmid_strobe: got %h want %h", fs_c, onehot(0));
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({fs_c == '0, busy_c, done_c, rdy_c} !== 4'b1000)
            $display("FAIL rstmid_clear: got zero/busy/done/rdy=%b want 1000",
                     {fs_c == '0, busy_c, done_c, rdy_c});
        else n_pass++;
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_c || fs_c != '0) dn++;
        end
        n_checks++;
        if (dn !== 0) $display("FAIL rstmid_no_done: got %0d want 0", dn);
        else n_pass++;
        col_c = 5'd16; fr_c = 5'd19; vc = 1'b1;
        tick();
        vc = 1'b0;
        hi = 0; dn = 0; bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (fs_c != '0) begin
                hi++;
                if (fs_c !== onehot(339)) bad++;
            end
            if (done_c) dn++;
            tick();
        end
        n_checks++;
        if ({hi, bad, dn} !== {32'd4, 32'd0, 32'd1})
            $display("FAIL rstmid_fresh: got hi=%0d bad=%0d done=%0d want 4/0/1", hi, bad, dn);
        else n_pass++;
    endtask

    task automatic test_capture();
        col_a = 5'd5; fr_a = 5'd2; bc_a = 1'b0; va = 1'b1;
        tick();
        va = 1'b0; col_a = 5'd9; fr_a = 5'd11; bc_a = 1'b1;
        tick();
        n_checks++;
        if (fs_a !== onehot(102)) $display("FAIL capture: got %h want %h", fs_a, onehot(102));
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (done_a !== 1'b1) $display("FAIL capture_done: got %b want 1", done_a);
        else n_pass++;
    endtask

    initial begin
        va = 0; col_a = 0; fr_a = 0; bc_a = 0;
        vb = 0; col_b = 0; fr_b = 0; bc_b = 0;
        vc = 0; col_c = 0; fr_c = 0; bc_c = 0;
        test_reset();
        test_single();
        test_broadcast();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_capture();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
